// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned NREG_DEF  = 32;
    localparam int unsigned MAX_PORTS = 16;

    typedef enum logic {RF_INIT, RF_READY} rf_state_e;

    // Highest-index set bit wins, matching the write-port priority.
    function automatic int unsigned win_port(logic [MAX_PORTS-1:0] hits);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < MAX_PORTS; i++) begin
            if (hits[i]) w = i;
        end
        return w;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback/issue-side bus of the multi-port register file.
interface regfile_mp_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32,
    parameter int unsigned NRD  = 2,
    parameter int unsigned NWR  = 2
);
    localparam int unsigned AW = $clog2(NREG);

    logic [NRD*AW-1:0]    rs_id_i;
    logic [NRD*XLEN-1:0]  rs_data_o;
    logic [NRD-1:0]       rs_busy_o;
    logic [NWR-1:0]       we_i;
    logic [NWR*AW-1:0]    rd_id_i;
    logic [NWR*XLEN-1:0]  rd_data_i;
    logic                 alloc_en_i;
    logic [AW-1:0]        alloc_id_i;
    logic                 ready_o;
    logic [NREG*XLEN-1:0] regs_o;

    modport master (
        output rs_id_i, we_i, rd_id_i, rd_data_i, alloc_en_i, alloc_id_i,
        input  rs_data_o, rs_busy_o, ready_o, regs_o
    );

    modport slave (
        input  rs_id_i, we_i, rd_id_i, rd_data_i, alloc_en_i, alloc_id_i,
        output rs_data_o, rs_busy_o, ready_o, regs_o
    );
endinterface

// File: rtl/regfile_sb.sv
// Per-register busy scoreboard: set on issue, cleared on writeback.
module regfile_sb #(
    parameter int unsigned NREG = 32,
    parameter int unsigned NWR  = 2,
    localparam int unsigned AW  = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sweep_i,
    input  logic              alloc_en_i,
    input  logic [AW-1:0]     alloc_id_i,
    input  logic [NWR-1:0]    we_i,
    input  logic [NWR*AW-1:0] rd_id_i,
    output logic [NREG-1:0]   busy_o
);
    logic [NREG-1:0] busy_q, busy_d;

    // A same-cycle allocate is applied after the clears so the new issue wins.
    always_comb begin
        busy_d = busy_q;
        if (sweep_i) begin
            busy_d = '0;
        end else begin
            for (int unsigned j = 0; j < NWR; j++) begin
                if (we_i[j]) busy_d[rd_id_i[j*AW +: AW]] = 1'b0;
            end
            if (alloc_en_i) busy_d[alloc_id_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) busy_q <= '0;
        else      busy_q <= busy_d;
    end

    assign busy_o = busy_q;
endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port integer register file with write bypass,
// busy scoreboard and a post-reset zeroing sweep.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEF,
    parameter int unsigned NREG   = NREG_DEF,
    parameter int unsigned NRD    = 2,
    parameter int unsigned NWR    = 2,
    parameter int unsigned BYPASS = 1
) (
    input logic         clk,
    input logic         rst,
    regfile_mp_if.slave bus
);
    localparam int unsigned AW = $clog2(NREG);

    rf_state_e       state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] rf_q [NREG];
    logic [MAX_PORTS-1:0] wr_hit [NREG];
    int unsigned     wr_win [NREG];
    logic [NREG-1:0] busy;
    logic            sweep;

    assign sweep       = (state_q == RF_INIT);
    assign bus.ready_o = (state_q == RF_READY);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == RF_INIT) begin
            cnt_d = cnt_q + AW'(1);
            if (cnt_q == AW'(NREG - 1)) state_d = RF_READY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= RF_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Per-register write match vector; drives both the array update and the bypass.
    always_comb begin
        for (int unsigned r = 0; r < NREG; r++) begin
            wr_hit[r] = '0;
            for (int unsigned j = 0; j < NWR; j++) begin
                if (!sweep && bus.we_i[j] && r != 0 && bus.rd_id_i[j*AW +: AW] == AW'(r))
                    wr_hit[r][j] = 1'b1;
            end
            wr_win[r] = win_port(wr_hit[r]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if (sweep) begin
                rf_q[cnt_q] <= '0;
            end else begin
                for (int unsigned r = 1; r < NREG; r++) begin
                    if (|wr_hit[r]) rf_q[r] <= bus.rd_data_i[wr_win[r]*XLEN +: XLEN];
                end
            end
        end
    end

    regfile_sb #(
        .NREG (NREG),
        .NWR  (NWR)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .sweep_i    (sweep),
        .alloc_en_i (bus.alloc_en_i),
        .alloc_id_i (bus.alloc_id_i),
        .we_i       (bus.we_i),
        .rd_id_i    (bus.rd_id_i),
        .busy_o     (busy)
    );

    always_comb begin
        bus.rs_data_o = '0;
        bus.rs_busy_o = '0;
        for (int unsigned k = 0; k < NRD; k++) begin
            logic [AW-1:0] id;
            id = bus.rs_id_i[k*AW +: AW];
            if (!sweep && id != '0) begin
                bus.rs_busy_o[k] = busy[id];
                if (BYPASS != 0 && |wr_hit[id])
                    bus.rs_data_o[k*XLEN +: XLEN] = bus.rd_data_i[wr_win[id]*XLEN +: XLEN];
                else
                    bus.rs_data_o[k*XLEN +: XLEN] = rf_q[id];
            end
        end
    end

    // Image is held at zero while the sweep runs so never-written entries do not leak.
    always_comb begin
        bus.regs_o = '0;
        if (!sweep) begin
            for (int unsigned r = 1; r < NREG; r++) bus.regs_o[r*XLEN +: XLEN] = rf_q[r];
        end
    end
endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed table, corner sequences, random vs model.
module tb_regfile_mp;
    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned NRD  = 2;
    localparam int unsigned NWR  = 2;
    localparam int unsigned AW   = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    regfile_mp_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) bus ();

    regfile_mp #(
        .XLEN   (XLEN),
        .NREG   (NREG),
        .NRD    (NRD),
        .NWR    (NWR),
        .BYPASS (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [XLEN-1:0] m_rf   [NREG];
    logic            m_busy [NREG];

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wid0, wid1;
        logic [31:0] wd0, wd1;
        logic [4:0]  rs0;
        logic        alloc;
        logic [4:0]  aid;
        logic [31:0] exp_rd;
        logic [4:0]  chk;
        logic [31:0] exp_reg;
        logic        exp_busy;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_image(input string name);
        int bad;
        bad = -1;
        checks++;
        for (int r = NREG - 1; r >= 0; r--) begin
            if (bus.regs_o[r*XLEN +: XLEN] !== m_rf[r]) bad = r;
        end
        if (bad >= 0) begin
            failures++;
            $display("FAIL %s reg=%0d actual=%h required=%h", name, bad,
                     bus.regs_o[bad*XLEN +: XLEN], m_rf[bad]);
        end
    endtask

    task automatic set_in(input logic [1:0] we, input logic [4:0] wid0, input logic [4:0] wid1,
                          input logic [31:0] wd0, input logic [31:0] wd1, input logic [4:0] rs0,
                          input logic [4:0] rs1, input logic alloc, input logic [4:0] aid);
        bus.we_i       = we;
        bus.rd_id_i    = {wid1, wid0};
        bus.rd_data_i  = {wd1, wd0};
        bus.rs_id_i    = {rs1, rs0};
        bus.alloc_en_i = alloc;
        bus.alloc_id_i = aid;
    endtask

    task automatic idle();
        set_in(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0, 5'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic m_reset();
        for (int r = 0; r < NREG; r++) begin
            m_rf[r]   = '0;
            m_busy[r] = 1'b0;
        end
    endtask

    // Expected read: register 0 is zero; otherwise the highest enabled writer, else stored.
    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 0) return 32'd0;
        for (int j = NWR - 1; j >= 0; j--) begin
            if (bus.we_i[j] && bus.rd_id_i[j*AW +: AW] == a) return bus.rd_data_i[j*XLEN +: XLEN];
        end
        return m_rf[a];
    endfunction

    task automatic m_step();
        logic [4:0] id;
        for (int j = 0; j < NWR; j++) begin
            id = bus.rd_id_i[j*AW +: AW];
            if (bus.we_i[j] && id != 0) m_rf[id] = bus.rd_data_i[j*XLEN +: XLEN];
        end
        for (int j = 0; j < NWR; j++) begin
            id = bus.rd_id_i[j*AW +: AW];
            if (bus.we_i[j]) m_busy[id] = 1'b0;
        end
        if (bus.alloc_en_i && bus.alloc_id_i != 0) m_busy[bus.alloc_id_i] = 1'b1;
    endtask

    // Counts edges from reset release until ready_o, bounded.
    task automatic wait_ready(output int cycles);
        cycles = 0;
        while (!bus.ready_o && cycles < 100) begin
            tick();
            cycles++;
        end
    endtask

    initial begin
        int cycles;
        logic [4:0] rs0, rs1;

        vecs[0] = '{2'b01, 5'd3,  5'd0,  32'hDEADBEEF, 32'h0,        5'd3,  1'b0, 5'd0,
                    32'hDEADBEEF, 5'd3,  32'hDEADBEEF, 1'b0};
        vecs[1] = '{2'b11, 5'd7,  5'd7,  32'h11111111, 32'h22222222, 5'd7,  1'b0, 5'd0,
                    32'h22222222, 5'd7,  32'h22222222, 1'b0};
        vecs[2] = '{2'b01, 5'd0,  5'd0,  32'hFFFFFFFF, 32'h0,        5'd0,  1'b1, 5'd0,
                    32'h0,        5'd0,  32'h0,        1'b0};
        vecs[3] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        5'd3,  1'b1, 5'd9,
                    32'hDEADBEEF, 5'd9,  32'h0,        1'b1};
        vecs[4] = '{2'b01, 5'd9,  5'd0,  32'hAAAA5555, 32'h0,        5'd9,  1'b1, 5'd9,
                    32'hAAAA5555, 5'd9,  32'hAAAA5555, 1'b1};
        vecs[5] = '{2'b10, 5'd0,  5'd9,  32'h0,        32'h0BADF00D, 5'd9,  1'b0, 5'd0,
                    32'h0BADF00D, 5'd9,  32'h0BADF00D, 1'b0};
        vecs[6] = '{2'b11, 5'd12, 5'd13, 32'h00000001, 32'h00000002, 5'd12, 1'b0, 5'd0,
                    32'h00000001, 5'd13, 32'h00000002, 1'b0};
        vecs[7] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        5'd7,  1'b0, 5'd0,
                    32'h22222222, 5'd7,  32'h22222222, 1'b0};

        // Reset with writes held on x5; the sweep must ignore them.
        set_in(2'b11, 5'd5, 5'd5, 32'hCAFEF00D, 32'h12345678, 5'd5, 5'd5, 1'b1, 5'd5);
        repeat (3) tick();
        chk("reset_ready_low", 64'(bus.ready_o), 64'd0);
        rst = 1'b1;
        chk("init_rs_data_zero", 64'(bus.rs_data_o), 64'd0);
        chk("init_rs_busy_zero", 64'(bus.rs_busy_o), 64'd0);
        wait_ready(cycles);
        idle();
        chk("sweep_cycles", 64'(cycles), 64'd32);
        m_reset();
        chk_image("post_sweep_image");
        chk("post_sweep_x5", 64'(bus.regs_o[5*XLEN +: XLEN]), 64'd0);
        bus.rs_id_i = {5'd5, 5'd5};
        #1;
        chk("post_sweep_busy", 64'(bus.rs_busy_o), 64'd0);

        // Directed table.
        for (int i = 0; i < 8; i++) begin
            set_in(vecs[i].we, vecs[i].wid0, vecs[i].wid1, vecs[i].wd0, vecs[i].wd1,
                   vecs[i].rs0, vecs[i].chk, vecs[i].alloc, vecs[i].aid);
            #1;
            chk($sformatf("vec%0d_rd", i), 64'(bus.rs_data_o[0 +: XLEN]), 64'(vecs[i].exp_rd));
            m_step();
            tick();
            idle();
            bus.rs_id_i = {vecs[i].chk, 5'd0};
            #1;
            chk($sformatf("vec%0d_reg", i), 64'(bus.regs_o[vecs[i].chk*XLEN +: XLEN]),
                64'(vecs[i].exp_reg));
            chk($sformatf("vec%0d_busy", i), 64'(bus.rs_busy_o[1]), 64'(vecs[i].exp_busy));
        end
        chk_image("table_image");

        // Random traffic on a narrow address range to provoke collisions.
        for (int n = 0; n < 400; n++) begin
            rs0 = 5'($urandom_range(0, 15));
            rs1 = 5'($urandom_range(0, 15));
            set_in(2'($urandom), 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)),
                   $urandom, $urandom, rs0, rs1, 1'($urandom), 5'($urandom_range(0, 15)));
            #1;
            chk("rand_rd0", 64'(bus.rs_data_o[0 +: XLEN]), 64'(m_read(rs0)));
            chk("rand_rd1", 64'(bus.rs_data_o[XLEN +: XLEN]), 64'(m_read(rs1)));
            chk("rand_busy", 64'(bus.rs_busy_o), 64'({(rs1 != 0) && m_busy[rs1],
                                                      (rs0 != 0) && m_busy[rs0]}));
            m_step();
            tick();
            chk_image("rand_image");
        end
        idle();

        // Mid-operation reset with x4 written and x6 busy.
        set_in(2'b01, 5'd4, 5'd0, 32'h00001234, 32'h0, 5'd0, 5'd0, 1'b1, 5'd6);
        tick();
        idle();
        repeat (10) tick();
        chk("pre_reset_x4", 64'(bus.regs_o[4*XLEN +: XLEN]), 64'h1234);
        bus.rs_id_i = {5'd6, 5'd4};
        #1;
        chk("pre_reset_busy6", 64'(bus.rs_busy_o[1]), 64'd1);
        rst = 1'b0;
        tick();
        chk("rst_ready_low", 64'(bus.ready_o), 64'd0);
        chk("rst_busy_clear", 64'(bus.rs_busy_o), 64'd0);
        rst = 1'b1;
        // Writes and allocates during the sweep are ignored.
        set_in(2'b01, 5'd4, 5'd0, 32'h00005555, 32'h0, 5'd4, 5'd6, 1'b1, 5'd4);
        #1;
        chk("resweep_rd_zero", 64'(bus.rs_data_o), 64'd0);
        wait_ready(cycles);
        bus.we_i       = '0;
        bus.alloc_en_i = 1'b0;
        #1;
        chk("resweep_cycles", 64'(cycles), 64'd32);
        m_reset();
        chk("resweep_x4", 64'(bus.regs_o[4*XLEN +: XLEN]), 64'd0);
        chk_image("resweep_image");
        chk("resweep_busy", 64'(bus.rs_busy_o), 64'd0);
        chk("resweep_ready", 64'(bus.ready_o), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
